ysyx_23060229_mdu: RTL and testbench
====================================

// Module: ysyx_23060229_mdu
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit with its sequencing FSM; executes MUL* / DIV* / REM*.
//  Sits beside the EXU. The EXU forwards M-type ops here and stalls until the result handshake completes.
//  Iterative datapath: radix-2 shift-add multiply and restoring divide.
//  Signs are handled by operating on magnitudes and fixing up in a final cycle.
// PARAMETERS
//  XLEN   32               operand/result width
//  CNT_W  $clog2(XLEN)+1   iteration counter width (derived; do not override)
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous reset, active-low
//  in_valid   in   1     op request valid
//  in_ready   out  1     unit can accept an op; high only in IDLE
//  op         in   3     funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  src1       in   XLEN  rs1 value (dividend / multiplicand)
//  src2       in   XLEN  rs2 value (divisor / multiplier)
//  flush      in   1     kill the current op (synchronous)
//  out_valid  out  1     result valid; held until accepted
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  rd value; stable while out_valid
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; all internal regs=0.
//  Accept: in_valid&&in_ready at an edge latches op/src1/src2; IDLE->PREP.
//  States:
//   IDLE -> PREP  on accept.
//   PREP  1 cycle: form magnitudes per signedness (MULH: both signed; MULHSU: src1 only; DIV/REM: both).
//         Record the negate flag. Clear the accumulator. cnt=XLEN.
//         Special cases go directly to DONE with the result loaded:
//         - divisor==0: DIV/DIVU -> all ones; REM/REMU -> src1.
//         - DIV with src1==0x80000000 and src2==-1: quotient 0x80000000; REM -> 0.
//         Otherwise PREP -> ITER.
//   ITER  one bit per cycle; cnt decrements; after cnt reaches 0, ITER -> FIX.
//         MUL: 2*XLEN-bit product register; add the shifted multiplicand when the current multiplier LSB is 1.
//         DIV: remainder register shifted left by one, with the next dividend bit shifted in.
//              Trial subtract: if no borrow, quotient bit=1 and keep the difference; else restore.
//   FIX   1 cycle: conditional two's-complement.
//         Product: negate the full 2*XLEN-bit value.
//         Quotient: negate if operand signs differ.
//         Remainder: takes the sign of the dividend.
//         Select the low half (MUL) or high half (MULH*), or the quotient/remainder; load result; -> DONE.
//   DONE  out_valid=1; on out_ready -> IDLE. in_ready returns the following cycle (one bubble between ops).
//  Latency from the accept edge to out_valid high:
//   - normal ops: XLEN+2 edges (PREP 1 + ITER XLEN + FIX 1), i.e. 34 for XLEN=32.
//   - special cases: 1 edge.
//  out_valid and result are registered. result holds its value after acceptance until the next FIX/PREP load.
//  Flush: in any non-IDLE state -> IDLE at the next edge; out_valid drops; no result is produced.
//   - flush and accept in the same cycle: flush wins, the op is not accepted.
//   - flush in DONE with out_ready=1: treated as accepted-and-killed; -> IDLE.
//  in_valid while busy: ignored (in_ready=0). src1/src2 need not be held after accept.
//  rst_n low mid-op: immediately IDLE; partial state is discarded.
//  All arithmetic is unsigned on magnitudes. There are no X-producing paths; an undefined op cannot occur (3-bit full decode).
// TESTING
//  MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 34 edges after the accept edge.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 (REM -> 0); each valid 1 edge after accept.
//  Backpressure: hold out_ready=0 for 10 cycles -> out_valid and result are stable and in_ready=0; release -> IDLE, next op accepted 1 cycle later.
//  Flush at ITER cycle 5, and separately rst_n low at ITER cycle 20 -> IDLE and out_valid=0; a subsequent MUL 3*4 returns 12.

Source files
------------

// File: rtl/ysyx_23060229_mdu.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes. A final cycle applies
// the sign fix-up. Requests and results use a valid/ready handshake, and the unit accepts a new
// op only while idle.
module ysyx_23060229_mdu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  // Multiply: running product. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  // Multiplicand, shifted left one place per iteration.
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  // Multiply: multiplier shifted right. Divide: divisor magnitude.
  logic [XLEN-1:0]     mag2_q, mag2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode and magnitudes, computed from the latched request.
  logic            is_div, s1_signed, s2_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  // Sign handling and special-case detection for the latched operands.
  always_comb begin
    is_div    = op_q[2];
    s1_signed = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
    s2_signed = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
    a_neg     = s1_signed & a_q[XLEN-1];
    b_neg     = s2_signed & b_q[XLEN-1];
    mag_a     = a_neg ? (~a_q + 1'b1) : a_q;
    mag_b     = b_neg ? (~b_q + 1'b1) : b_q;
    div_zero  = (b_q == '0);
    // Only signed DIV/REM (op[0] clear) can overflow.
    div_ovf   = !op_q[0] && (a_q == MinNeg) && (b_q == {XLEN{1'b1}});
  end

  logic [2*XLEN-1:0] div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   dq_sel;

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mag2_d    = mag2_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    result_d  = result_q;
    div_shift = {acc_q[2*XLEN-2:0], 1'b0};
    div_trial = {1'b0, div_shift[2*XLEN-1:XLEN]} - {1'b0, mag2_q};
    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    dq_sel    = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

    if (flush) begin
      // Flush kills any op in flight and blocks a same-cycle accept.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_d    = op;
            a_d     = src1;
            b_d     = src2;
            state_d = StPrep;
          end
        end
        StPrep: begin
          cnt_d  = CNT_W'(XLEN);
          mag2_d = mag_b;
          unique case (op_q)
            3'd1, 3'd4: neg_d = a_neg ^ b_neg;
            3'd2, 3'd6: neg_d = a_neg;
            default:    neg_d = 1'b0;
          endcase
          if (is_div) begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            mcand_d = '0;
          end else begin
            acc_d   = '0;
            mcand_d = {{XLEN{1'b0}}, mag_a};
          end
          if (is_div && div_zero) begin
            result_d = op_q[1] ? a_q : {XLEN{1'b1}};
            state_d  = StDone;
          end else if (is_div && div_ovf) begin
            result_d = op_q[1] ? '0 : MinNeg;
            state_d  = StDone;
          end else begin
            state_d = StIter;
          end
        end
        StIter: begin
          cnt_d = cnt_q - 1'b1;
          if (is_div) begin
            // Restoring step: keep the difference only when there is no borrow.
            if (!div_trial[XLEN]) begin
              acc_d = {div_trial[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
            end else begin
              acc_d = div_shift;
            end
          end else begin
            if (mag2_q[0]) begin
              acc_d = acc_q + mcand_q;
            end
            mcand_d = {mcand_q[2*XLEN-2:0], 1'b0};
            mag2_d  = {1'b0, mag2_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = StFix;
          end
        end
        StFix: begin
          if (is_div) begin
            result_d = neg_q ? (~dq_sel + 1'b1) : dq_sel;
          end else if (op_q == 3'd0) begin
            result_d = prod_fix[XLEN-1:0];
          end else begin
            result_d = prod_fix[2*XLEN-1:XLEN];
          end
          state_d = StDone;
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mag2_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mag2_q   <= mag2_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_23060229_mdu.sv
// Self-checking bench for the RV32M multiply/divide unit.
module tb_ysyx_23060229_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad = 0;

  ysyx_23060229_mdu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return 32'(ua / ub);
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return 32'(ua % ub);
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Present an op, count edges to out_valid, check latency and result; leaves the unit in DONE.
  task automatic start_wait(input string tag, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b);
    int n;
    in_valid = 1'b1;
    op   = f;
    src1 = a;
    src2 = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1 = $urandom;
    src2 = $urandom;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check({tag, "_lat"}, 32'(n), 32'(model_lat(f, a, b)));
    check({tag, "_res"}, result, model(f, a, b));
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    start_wait(tag, f, a, b);
    ack(tag);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb, expv;
    int          sel;

    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, with hardcoded golden values as well as the model.
    start_wait("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_gold", result, 32'hFFFF_FFEB);
    ack("mul");
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    start_wait("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulhsu_gold", result, 32'hFFFF_FFFF);
    ack("mulhsu");
    start_wait("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
    check("div_gold", result, 32'hFFFF_FFFD);
    ack("div");
    start_wait("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
    check("rem_gold", result, 32'hFFFF_FFFF);
    ack("rem");
    start_wait("divu", 3'd5, 32'd100, 32'd7);
    check("divu_gold", result, 32'd14);
    ack("divu");
    start_wait("remu", 3'd7, 32'd100, 32'd7);
    check("remu_gold", result, 32'd2);
    ack("remu");
    start_wait("divu0", 3'd5, 32'd5, 32'd0);
    check("divu0_gold", result, 32'hFFFF_FFFF);
    ack("divu0");
    do_op("rem0", 3'd6, 32'd5, 32'd0);
    do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("mulh_neg", 3'd1, 32'hFFFF_FFFE, 32'd3);
    do_op("rem_neg", 3'd6, 32'd7, 32'hFFFF_FFFE);

    // Backpressure: result held and no new op accepted while out_ready is low.
    start_wait("bp", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    expv = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    in_valid = 1'b1;
    op = 3'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_result", result, expv);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    ack("bp");
    do_op("bp_next", 3'd0, 32'd9, 32'd11);

    // Flush during ITER.
    in_valid = 1'b1;
    op = 3'd0;
    src1 = 32'd123;
    src2 = 32'd456;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_no_result", {31'b0, out_valid}, 32'd0);

    // Flush and accept together: flush wins.
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_accept_busy", {31'b0, busy}, 32'd0);

    // Flush in DONE with out_ready high.
    start_wait("fdone", 3'd5, 32'd50, 32'd3);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    check("fdone_valid", {31'b0, out_valid}, 32'd0);
    check("fdone_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset during ITER.
    in_valid = 1'b1;
    op = 3'd4;
    src1 = 32'hDEAD_BEEF;
    src2 = 32'd17;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_wait("post_rst", 3'd0, 32'd3, 32'd4);
    check("post_rst_gold", result, 32'd12);
    ack("post_rst");

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'd0;
      if (sel == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if (sel == 2) rb = 32'($urandom_range(1, 15));
      if (sel == 3) ra = -ra;
      do_op("rand", rf, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
